digit_serial_adder: RTL



---
 rtl/adder_pkg.sv | 19 +
 rtl/digit_adder.sv | 30 +++
 rtl/full_adder.sv | 13 +
 rtl/digit_serial_adder.sv | 108 ++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Digit counter needs at least one bit even when a single digit covers the word.
  function automatic int cnt_width(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the digit ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/digit_serial_adder.sv
// Adds/subtracts two WIDTH-bit operands DIGIT bits per clock with valid/ready on both sides.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
  localparam int CNT_W      = cnt_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_DIGITS - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("digit_serial_adder: DIGIT must divide WIDTH exactly");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, sum_sh, sum_nxt;
  logic             carry;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout, d_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_r[DIGIT-1:0]),
    .b     (b_r[DIGIT-1:0]),
    .cin   (carry),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // New digit enters at the MSB end so the word is aligned after the last digit.
  assign sum_nxt = (sum_sh >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters and running carry; subtraction is folded in as A + ~B + ~Cin.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_r   <= A;
      b_r   <= B ^ {WIDTH{SUB}};
      carry <= Cin ^ SUB;
    end else if (state == BUSY) begin
      a_r    <= a_r >> DIGIT;
      b_r    <= b_r >> DIGIT;
      carry  <= d_cout;
      sum_sh <= sum_nxt;
    end
  end

  // Digit counter and the captured result, which holds until the next capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      S    <= '0;
      Cout <= 1'b0;
      OVF  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        S    <= sum_nxt;
        Cout <= d_cout;
        OVF  <= d_cmsb ^ d_cout;
      end
    end
  end

endmodule
